// File: rtl/bmd_lat_pkg.sv
// Shared constants and state type for the echo latency measurement block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bmd_lat_pkg;

    localparam int CNT_W     = 38;
    localparam int ADDR_W    = 13;
    localparam int LAT_DEPTH = 1 << ADDR_W;
    localparam int SUM_W     = 54;
    localparam int NUM_W     = 32;

    typedef enum logic [1:0] {
        LAT_IDLE = 2'd0,
        LAT_RUN  = 2'd1,
        LAT_CLR0 = 2'd2,
        LAT_CLR1 = 2'd3
    } lat_state_t;

endpackage

// File: rtl/bmd_lat_stats.sv
// Min/max/saturating-sum/saturating-count accumulator for latency samples.
// Latency: statistics reflect a sample one cycle after its lat_vld strobe.
// Backpressure: none; accepts one sample per cycle, clr wins over a sample.
module bmd_lat_stats #(
    parameter int CNT_W = bmd_lat_pkg::CNT_W,
    parameter int SUM_W = bmd_lat_pkg::SUM_W,
    parameter int NUM_W = bmd_lat_pkg::NUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             lat_vld,
    input  logic [CNT_W-1:0] lat_val,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [SUM_W-1:0] lat_sum,
    output logic [NUM_W-1:0] lat_num
);

    // One extra bit catches the carry out of the running sum.
    logic [SUM_W:0] sum_ext;

    // Widen the sample to the accumulator width and add.
    always_comb begin
        sum_ext = {1'b0, lat_sum} + {{(SUM_W + 1 - CNT_W){1'b0}}, lat_val};
    end

    // Update statistics on every valid sample; clear restores the empty-set values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lat_min <= '1;
            lat_max <= '0;
            lat_sum <= '0;
            lat_num <= '0;
        end else if (lat_vld) begin
            if (lat_val < lat_min) lat_min <= lat_val;
            if (lat_val > lat_max) lat_max <= lat_val;
            lat_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
            if (lat_num != '1) lat_num <= lat_num + NUM_W'(1);
        end
    end

endmodule

// File: rtl/bmd_256_latency_ctrl.sv
// Sequences the timestamp BRAM: stamps on TX echo send, reads/subtracts on RX echo return.
// Latency: write same cycle; lat_vld at read issue+2; statistics at issue+3.
// Backpressure: tx_stamp_rdy low when full or not running; full stamps dropped (ovf), empty echoes dropped (unf).
module bmd_256_latency_ctrl #(
    parameter int CNT_W  = bmd_lat_pkg::CNT_W,
    parameter int ADDR_W = bmd_lat_pkg::ADDR_W,
    parameter int SUM_W  = bmd_lat_pkg::SUM_W,
    parameter int NUM_W  = bmd_lat_pkg::NUM_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              meas_en,
    input  logic              user_clr,
    input  logic [CNT_W-1:0]  latency_counter,
    input  logic              tx_stamp_req,
    output logic              tx_stamp_rdy,
    input  logic              rx_echo_vld,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [CNT_W-1:0]  bram_wr_data,
    output logic              bram_reb,
    output logic [ADDR_W-1:0] bram_rd_addr,
    output logic              bram_rstb,
    input  logic [CNT_W-1:0]  bram_rd_data,
    output logic              lat_vld,
    output logic [CNT_W-1:0]  lat_val,
    output logic [CNT_W-1:0]  lat_min,
    output logic [CNT_W-1:0]  lat_max,
    output logic [SUM_W-1:0]  lat_sum,
    output logic [NUM_W-1:0]  lat_num,
    output logic [ADDR_W:0]   outstanding,
    output logic              ovf_flag,
    output logic              unf_flag
);

    import bmd_lat_pkg::*;

    lat_state_t        state, state_nxt;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              run, full, empty, in_clr;
    logic              wr_go, rd_go;
    logic              s1_vld, s2_vld;
    logic [CNT_W-1:0]  s1_t, s2_t;

    // outstanding never exceeds 2^ADDR_W, so its top bit alone means "full".
    assign run    = (state == LAT_RUN);
    assign in_clr = (state == LAT_CLR0);
    assign full   = outstanding[ADDR_W];
    assign empty  = (outstanding == '0);
    assign wr_go  = run && tx_stamp_req && !full;
    assign rd_go  = run && rx_echo_vld && !empty;

    assign tx_stamp_rdy = run && !full;
    assign bram_ena     = wr_go;
    assign bram_wea     = wr_go;
    assign bram_wr_addr = wr_go ? wr_ptr : '0;
    assign bram_wr_data = wr_go ? latency_counter : '0;
    assign bram_reb     = rd_go;
    assign bram_rd_addr = rd_go ? rd_ptr : '0;
    assign bram_rstb    = in_clr;

    // Samples still in flight when a clear lands are suppressed.
    assign lat_vld = s2_vld && !in_clr;
    assign lat_val = lat_vld ? (s2_t - bram_rd_data) : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= LAT_IDLE;
        else     state <= state_nxt;
    end

    // Next state: clear always wins, then the two-step clear, then meas_en.
    always_comb begin
        state_nxt = state;
        if (user_clr) begin
            state_nxt = LAT_CLR0;
        end else begin
            case (state)
                LAT_CLR0: state_nxt = LAT_CLR1;
                default:  state_nxt = meas_en ? LAT_RUN : LAT_IDLE;
            endcase
        end
    end

    // Ring pointers, occupancy and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst || in_clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            ovf_flag    <= 1'b0;
            unf_flag    <= 1'b0;
        end else begin
            if (wr_go) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (rd_go) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_go, rd_go})
                2'b10:   outstanding <= outstanding + (ADDR_W+1)'(1);
                2'b01:   outstanding <= outstanding - (ADDR_W+1)'(1);
                default: outstanding <= outstanding;
            endcase
            if (run && tx_stamp_req && full)  ovf_flag <= 1'b1;
            if (run && rx_echo_vld && empty)  unf_flag <= 1'b1;
        end
    end

    // Arrival time rides alongside the two-cycle BRAM read; keeps draining outside RUN.
    always_ff @(posedge clk) begin
        if (rst || in_clr) begin
            s1_vld <= 1'b0;
            s2_vld <= 1'b0;
            s1_t   <= '0;
            s2_t   <= '0;
        end else begin
            s1_vld <= rd_go;
            s1_t   <= latency_counter;
            s2_vld <= s1_vld;
            s2_t   <= s1_t;
        end
    end

    bmd_lat_stats #(
        .CNT_W (CNT_W),
        .SUM_W (SUM_W),
        .NUM_W (NUM_W)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .clr     (in_clr),
        .lat_vld (lat_vld),
        .lat_val (lat_val),
        .lat_min (lat_min),
        .lat_max (lat_max),
        .lat_sum (lat_sum),
        .lat_num (lat_num)
    );

endmodule

// File: tb/tb_bmd_256_latency_ctrl.sv
// Bench for bmd_256_latency_ctrl: BRAM model, queue-based reference model, directed and random stimulus.
module tb_bmd_256_latency_ctrl;

    localparam int DEPTH = 8192;
    localparam longint unsigned MASK = 64'h3F_FFFF_FFFF;
    localparam longint unsigned SMAX = 64'h3F_FFFF_FFFF_FFFF;
    localparam longint unsigned NMAX = 64'hFFFF_FFFF;
    localparam int PH_IDLE = 0, PH_RUN = 1, PH_CLR0 = 2, PH_CLR1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        meas_en = 1'b0;
    logic        user_clr = 1'b0;
    logic [37:0] latency_counter = '0;
    logic        tx_stamp_req = 1'b0;
    logic        rx_echo_vld = 1'b0;

    logic        tx_stamp_rdy, bram_ena, bram_wea, bram_reb, bram_rstb;
    logic [12:0] bram_wr_addr, bram_rd_addr;
    logic [37:0] bram_wr_data, bram_rd_data;
    logic        lat_vld, ovf_flag, unf_flag;
    logic [37:0] lat_val, lat_min, lat_max;
    logic [53:0] lat_sum;
    logic [31:0] lat_num;
    logic [13:0] outstanding;

    int n_tests = 0;
    int n_fail  = 0;

    bmd_256_latency_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .meas_en         (meas_en),
        .user_clr        (user_clr),
        .latency_counter (latency_counter),
        .tx_stamp_req    (tx_stamp_req),
        .tx_stamp_rdy    (tx_stamp_rdy),
        .rx_echo_vld     (rx_echo_vld),
        .bram_ena        (bram_ena),
        .bram_wea        (bram_wea),
        .bram_wr_addr    (bram_wr_addr),
        .bram_wr_data    (bram_wr_data),
        .bram_reb        (bram_reb),
        .bram_rd_addr    (bram_rd_addr),
        .bram_rstb       (bram_rstb),
        .bram_rd_data    (bram_rd_data),
        .lat_vld         (lat_vld),
        .lat_val         (lat_val),
        .lat_min         (lat_min),
        .lat_max         (lat_max),
        .lat_sum         (lat_sum),
        .lat_num         (lat_num),
        .outstanding     (outstanding),
        .ovf_flag        (ovf_flag),
        .unf_flag        (unf_flag)
    );

    initial forever #5 clk = ~clk;

    // Dual-port BRAM with a two-register read path and output reset.
    logic [37:0] mem [0:DEPTH-1];
    logic [37:0] q1 = '0;
    logic [37:0] q2 = '0;
    assign bram_rd_data = q2;
    always @(posedge clk) begin
        if (bram_ena && bram_wea) mem[bram_wr_addr] <= bram_wr_data;
        if (bram_rstb) begin
            q1 <= '0;
            q2 <= '0;
        end else begin
            if (bram_reb) q1 <= mem[bram_rd_addr];
            q2 <= q1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of stamp values plus a list of (due cycle, latency).
    int               m_phase;
    longint unsigned  stamps[$];
    longint unsigned  due_q[$];
    longint unsigned  lat_q[$];
    int               m_wptr, m_rptr;
    bit               m_ovf, m_unf;
    longint unsigned  m_min, m_max, m_sum, m_num;
    longint unsigned  cyc = 0;

    task automatic model_reset();
        m_phase = PH_IDLE;
        stamps.delete(); due_q.delete(); lat_q.delete();
        m_wptr = 0; m_rptr = 0; m_ovf = 0; m_unf = 0;
        m_min = MASK; m_max = 0; m_sum = 0; m_num = 0;
    endtask

    task automatic model_cycle();
        bit run, full, empty, ewr, erd, due, evld;
        longint unsigned elat, ts;
        run   = (m_phase == PH_RUN);
        full  = (stamps.size() == DEPTH);
        empty = (stamps.size() == 0);
        ewr   = run && tx_stamp_req && !full;
        erd   = run && rx_echo_vld && !empty;
        due   = (due_q.size() != 0) && (due_q[0] == cyc);
        evld  = due && (m_phase != PH_CLR0);
        elat  = evld ? lat_q[0] : 0;

        chk("bram_ena", bram_ena, ewr);
        chk("bram_wea", bram_wea, ewr);
        if (ewr) begin
            chk("bram_wr_addr", bram_wr_addr, m_wptr);
            chk("bram_wr_data", bram_wr_data, latency_counter);
        end
        chk("bram_reb", bram_reb, erd);
        if (erd) chk("bram_rd_addr", bram_rd_addr, m_rptr);
        chk("bram_rstb", bram_rstb, m_phase == PH_CLR0);
        chk("tx_stamp_rdy", tx_stamp_rdy, run && !full);
        chk("outstanding", outstanding, stamps.size());
        chk("ovf_flag", ovf_flag, m_ovf);
        chk("unf_flag", unf_flag, m_unf);
        chk("lat_vld", lat_vld, evld);
        chk("lat_val", lat_val, elat);
        chk("lat_min", lat_min, m_min);
        chk("lat_max", lat_max, m_max);
        chk("lat_sum", lat_sum, m_sum);
        chk("lat_num", lat_num, m_num);

        if (due) begin
            void'(due_q.pop_front());
            void'(lat_q.pop_front());
        end
        if (evld) begin
            if (elat < m_min) m_min = elat;
            if (elat > m_max) m_max = elat;
            m_sum = (m_sum + elat > SMAX) ? SMAX : m_sum + elat;
            if (m_num < NMAX) m_num = m_num + 1;
        end
        if (m_phase == PH_CLR0) begin
            stamps.delete(); due_q.delete(); lat_q.delete();
            m_wptr = 0; m_rptr = 0; m_ovf = 0; m_unf = 0;
            m_min = MASK; m_max = 0; m_sum = 0; m_num = 0;
        end else begin
            if (run && tx_stamp_req && full) m_ovf = 1;
            if (run && rx_echo_vld && empty) m_unf = 1;
            if (erd) begin
                ts = stamps.pop_front();
                lat_q.push_back((longint'(latency_counter) - ts) & MASK);
                due_q.push_back(cyc + 2);
                m_rptr = (m_rptr + 1) % DEPTH;
            end
            if (ewr) begin
                stamps.push_back(longint'(latency_counter));
                m_wptr = (m_wptr + 1) % DEPTH;
            end
        end
        if (user_clr)                 m_phase = PH_CLR0;
        else if (m_phase == PH_CLR0)  m_phase = PH_CLR1;
        else                          m_phase = meas_en ? PH_RUN : PH_IDLE;
        cyc++;
    endtask

    // Compare process: checks every cycle on the falling edge, then advances the model.
    initial forever begin
        @(negedge clk);
        if (rst) model_reset();
        else     model_cycle();
    end

    // Inputs change just after the rising edge; outputs are inspected at the next falling edge.
    task automatic drive(input bit en, input bit clr, input bit t, input bit r, input logic [37:0] c);
        @(posedge clk);
        #1;
        meas_en = en; user_clr = clr; tx_stamp_req = t; rx_echo_vld = r; latency_counter = c;
        @(negedge clk);
    endtask

    task automatic do_clear();
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        chk("clr_rstb", bram_rstb, 1);
        drive(1, 0, 0, 0, 0);
        chk("clr_min", lat_min, 64'h3F_FFFF_FFFF);
        chk("clr_num", lat_num, 0);
        chk("clr_outstanding", outstanding, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [37:0] c;
        longint unsigned got[$];
        int at[$];
        longint unsigned exp_b2b [4] = '{100, 91, 82, 73};
        bit en, clr, t, r;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_min", lat_min, 64'h3F_FFFF_FFFF);
        chk("rst_max", lat_max, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_rdy", tx_stamp_rdy, 0);
        chk("rst_vld", lat_vld, 0);
        chk("rst_ena", bram_ena, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single sample: 350 - 100
        drive(1, 0, 0, 0, 90);
        drive(1, 0, 1, 0, 100);
        chk("t1_wr_addr", bram_wr_addr, 0);
        chk("t1_wr_data", bram_wr_data, 100);
        drive(1, 0, 0, 0, 200);
        drive(1, 0, 0, 1, 350);
        chk("t1_reb", bram_reb, 1);
        chk("t1_rd_addr", bram_rd_addr, 0);
        drive(1, 0, 0, 0, 351);
        chk("t1_vld_early", lat_vld, 0);
        drive(1, 0, 0, 0, 352);
        chk("t1_vld", lat_vld, 1);
        chk("t1_val", lat_val, 250);
        drive(1, 0, 0, 0, 353);
        chk("t1_min", lat_min, 250);
        chk("t1_max", lat_max, 250);
        chk("t1_sum", lat_sum, 250);
        chk("t1_num", lat_num, 1);

        // Counter wrap: 15 - (2^38 - 10)
        do_clear();
        drive(1, 0, 1, 0, 38'h3F_FFFF_FFF6);
        drive(1, 0, 0, 1, 15);
        drive(1, 0, 0, 0, 16);
        drive(1, 0, 0, 0, 17);
        chk("wrap_vld", lat_vld, 1);
        chk("wrap_val", lat_val, 25);

        // Back-to-back reads
        do_clear();
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 38'(10 * (i + 1)));
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, 0, i < 4, 38'(110 + i));
            if (lat_vld) begin
                got.push_back(longint'(lat_val));
                at.push_back(i);
            end
        end
        chk("b2b_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            chk("b2b_val", got[k], exp_b2b[k]);
            chk("b2b_slot", at[k], k + 2);
        end
        chk("b2b_min", lat_min, 73);
        chk("b2b_max", lat_max, 100);
        chk("b2b_sum", lat_sum, 346);
        chk("b2b_num", lat_num, 4);

        // Underflow alongside a write, then simultaneous write and read
        do_clear();
        drive(1, 0, 1, 1, 500);
        chk("unf_no_reb", bram_reb, 0);
        chk("unf_ena", bram_ena, 1);
        drive(1, 0, 0, 0, 501);
        chk("unf_flag", unf_flag, 1);
        chk("unf_outstanding", outstanding, 1);
        drive(1, 0, 1, 1, 600);
        chk("sim_ena", bram_ena, 1);
        chk("sim_reb", bram_reb, 1);
        chk("sim_rd_addr", bram_rd_addr, 0);
        chk("sim_wr_addr", bram_wr_addr, 1);
        drive(1, 0, 0, 0, 601);
        chk("sim_outstanding", outstanding, 1);
        drive(1, 0, 0, 0, 602);
        chk("sim_val", lat_val, 100);

        // Clear one cycle after a read issue
        do_clear();
        drive(1, 0, 1, 0, 1000);
        drive(1, 0, 0, 1, 1010);
        drive(1, 1, 0, 0, 1011);
        chk("mid_vld0", lat_vld, 0);
        drive(1, 0, 0, 0, 1012);
        chk("mid_rstb", bram_rstb, 1);
        chk("mid_vld1", lat_vld, 0);
        drive(1, 0, 0, 0, 1013);
        chk("mid_vld2", lat_vld, 0);
        chk("mid_min", lat_min, 64'h3F_FFFF_FFFF);
        chk("mid_num", lat_num, 0);
        drive(1, 0, 0, 0, 1014);
        chk("mid_vld3", lat_vld, 0);
        drive(1, 0, 1, 0, 1015);
        chk("mid_resume_ena", bram_ena, 1);
        chk("mid_resume_addr", bram_wr_addr, 0);

        // Fill to full, overflow, then one echo
        do_clear();
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 1, 0, 38'(i));
        drive(1, 0, 0, 0, 8300);
        chk("full_rdy", tx_stamp_rdy, 0);
        chk("full_outstanding", outstanding, 8192);
        drive(1, 0, 1, 0, 8301);
        chk("full_drop", bram_ena, 0);
        drive(1, 0, 0, 0, 8302);
        chk("full_ovf", ovf_flag, 1);
        drive(1, 0, 0, 1, 9000);
        chk("full_reb", bram_reb, 1);
        chk("full_rd_addr", bram_rd_addr, 0);
        drive(1, 0, 1, 0, 9001);
        chk("full_wrap_addr", bram_wr_addr, 0);
        drive(1, 0, 0, 0, 9002);
        chk("full_val", lat_val, 9000);
        chk("full_refill", outstanding, 8192);

        // Random traffic near the counter wrap, with enable toggles and clears
        do_clear();
        c = 38'h3F_FFFF_F000;
        en = 1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) en = !en;
            clr = ($urandom_range(0, 199) == 0);
            t   = ($urandom_range(0, 99) < 50);
            r   = ($urandom_range(0, 99) < 45);
            drive(en, clr, t, r, c);
            c = c + 38'(1 + $urandom_range(0, 3));
        end
        drive(0, 0, 0, 0, c);
        drive(0, 0, 0, 0, c);
        drive(0, 0, 0, 0, c);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
